mul_seq: RTL
============

# mul_seq

Multi-cycle 16x16 unsigned shift-add multiplier sequencer that borrows the shared 16-bit ALU instead of adding a hardware multiplier. It sits beside the execute-stage ALU. It requests the ALU, drives its operand/opcode inputs while granted, and returns the low 16 bits of the product plus an unsigned overflow flag. The parent instantiates the ALU and muxes its inputs between the pipeline and this block using `alu_gnt`.

## Interface
- `ITER`, default 16: iteration count; equals the operand width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply; sampled only when `busy`=0.
- `a` in 16: multiplicand; captured with `start`.
- `b` in 16: multiplier; captured with `start`.
- `busy` out 1: high in ADD/SHIFT states.
- `done` out 1: one-cycle pulse when the result is valid.
- `prod` out 16: low 16 bits of a*b; held until the next accepted `start`.
- `ovf` out 1: high if the true 32-bit product exceeds 16 bits; held with `prod`.
- `alu_req` out 1: equals `busy`.
- `alu_gnt` in 1: the ALU inputs are ours this cycle; state advances only when high.
- `alu_A`, `alu_B` out 16: ALU operands.
- `alu_Cin`, `alu_sign` out 1: always 0.
- `alu_Op` out 3: ALU opcode.
- `alu_Out` in 16: ALU result, combinational, same cycle.
- `alu_OFL` in 1: ALU overflow; equals carry-out because `alu_sign`=0.

## Operation
- Registers:
  - `mcand` (16): captured from `a`.
  - `mplier` (16): captured from `b`.
  - `acc` (16): running product.
  - `cnt` (5): iteration count.
  - `ovf_r`: sticky overflow.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE/DONE with `start`=1:
  - Load `mcand`=a, `mplier`=b, `acc`=0, `cnt`=0, `ovf_r`=0.
  - Next state is ADD if b[0] else SHIFT.
- ADD (`alu_gnt`=1):
  - Drive `alu_A`=acc, `alu_B`=mcand, `alu_Op`=3'd4 (ADD).
  - acc<=alu_Out; ovf_r|=alu_OFL; next state SHIFT.
- SHIFT (`alu_gnt`=1):
  - Drive `alu_A`=mcand, `alu_B`=16'd1, `alu_Op`=3'd1 (SLL).
  - mcand<=alu_Out; mplier<=mplier>>1; cnt<=cnt+1.
  - ovf_r|= mcand[15] & ((mplier>>1)!=0).
  - If cnt+1==ITER, go to DONE. Otherwise go to ADD if mplier[1] else SHIFT.
- Any state with `alu_gnt`=0 and `busy`=1: hold every register and keep driving the same ALU inputs.
- DONE:
  - `done`=1; prod<=acc and ovf<=ovf_r are registered on entry.
  - Next state is IDLE unless `start`=1.
- IDLE/DONE ALU drive: `alu_A`=`alu_B`=0, `alu_Op`=3'd4.
- `start` while `busy`=1 is ignored; there is no queueing.
- Reset, including mid-operation:
  - State goes to IDLE.
  - `busy`, `done`, `alu_req`, `ovf` = 0; `prod`=0.
  - All ALU drive outputs = 0 except `alu_Op`=3'd4.
- Arithmetic is modulo 2^16. Signed operands yield the correct low 16 bits, but `ovf` is meaningful only for unsigned operands.

## Timing
- `start` sampled at cycle 0. Without the early-exit feature and with `alu_gnt` held high:
  - ALU cycles 1..(16+p), where p = popcount(b).
  - `done` is high in cycle 17+p; `prod`/`ovf` are valid from the same cycle.
- Each `alu_gnt`=0 cycle during `busy` adds exactly one cycle of latency.
- Back-to-back: `start` during the DONE cycle is accepted, and `busy` rises the next cycle.
- `done` never coincides with `busy`.

## Configuration
- Macro: `MUL_SEQ_EARLY_EXIT_EN`.
- Defined:
  - SHIFT goes to DONE when (mplier>>1)==0, in addition to the cnt condition.
  - `start` with b==0 goes directly to DONE (`done` in cycle 1, prod=0).
  - Latency becomes (index of highest set bit of b) + 1 + p + 1.
- Undefined: always runs 16 SHIFT iterations. The latency depends only on p, not on the position of the top set bit.

## Structure
- `mul_seq_pkg`:
  - State enum: IDLE, ADD, SHIFT, DONE.
  - ALU opcode constants: OP_SLL=3'd1, OP_ADD=3'd4.
- No sub-module is needed; the ALU is instantiated and muxed by the parent. The counter and overflow logic stay inline.

## Test plan
- a=3, b=5, gnt=1 → prod=15, ovf=0, `done` in cycle 19 (early-exit build: cycle 6).
- a=16'hFFFF, b=16'hFFFF → prod=16'h0001, ovf=1; `busy` held exactly 32 cycles (non-early-exit build).
- a=16'h0100, b=16'h0100 → prod=0, ovf=1. a=16'h00FF, b=16'h0101 → prod=16'hFFFF, ovf=0.
- a=7, b=9 with `alu_gnt` low on every other cycle → prod=63, latency = ungated latency + number of low-gnt cycles; ALU inputs stable during each stall.
- `start` asserted mid-operation (ignored); then `rst` asserted mid-operation → IDLE next cycle, all outputs 0. A following start with a=2, b=0 → prod=0, ovf=0.
- Back-to-back: second `start` (a=4, b=4) in the DONE cycle of a=2, b=3 → first prod=6, then prod=16, with no idle cycle in between.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared types and constants for the shift-add multiply sequencer.
//   state_t : sequencer states (IDLE, ADD, SHIFT, DONE)
//   OP_SLL  : shared-ALU opcode for shift-left-logical
//   OP_ADD  : shared-ALU opcode for add (also the idle opcode)
//   first_state() : state entered after an accepted start, from bit 0 of b
// -----------------------------------------------------------------------------
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd4;

    // A set multiplier LSB needs an add before its first shift.
    function automatic state_t first_state(input logic i_b0);
        return i_b0 ? ADD : SHIFT;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Multi-cycle 16x16 unsigned shift-add multiplier that borrows the shared
// execute-stage ALU rather than owning a hardware multiplier. The parent muxes
// the ALU inputs between the pipeline and this block using i_alu_gnt.
//
// Ports
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : multiply request, only sampled while not busy
//   i_a, i_b          : multiplicand / multiplier, captured with i_start
//   o_busy            : high in ADD/SHIFT
//   o_done            : one-cycle pulse, result valid
//   o_prod, o_ovf     : low 16 product bits, unsigned overflow (held)
//   o_alu_req         : ALU request (same as o_busy)
//   i_alu_gnt         : ALU inputs belong to us this cycle
//   o_alu_A/B/Op      : ALU operands and opcode
//   o_alu_Cin/sign    : tied low
//   i_alu_Out/OFL     : combinational ALU result and carry-out
//
// Build option
//   MUL_SEQ_EARLY_EXIT_EN : finish as soon as no multiplier bits remain,
//                           and complete b==0 immediately.
// -----------------------------------------------------------------------------
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_prod,
    output logic        o_ovf,
    output logic        o_alu_req,
    input  logic        i_alu_gnt,
    output logic [15:0] o_alu_A,
    output logic [15:0] o_alu_B,
    output logic        o_alu_Cin,
    output logic        o_alu_sign,
    output logic [2:0]  o_alu_Op,
    input  logic [15:0] i_alu_Out,
    input  logic        i_alu_OFL
);

    state_t      r_state;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_ovf_r;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_prod;
    logic        r_ovf;

    logic [4:0]  w_cnt_nxt;
    logic [15:0] w_mplier_sh;
    logic        w_shift_ovf;
    logic        w_last;
    logic        w_accept;

    assign w_cnt_nxt   = r_cnt + 5'd1;
    assign w_mplier_sh = r_mplier >> 1;
    // A set bit leaving mcand[15] is lost; the product overflows if any
    // multiplier bit still remains to be applied after this shift.
    assign w_shift_ovf = r_ovf_r | (r_mcand[15] & (w_mplier_sh != 16'd0));

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign w_last = (w_cnt_nxt == 5'(ITER)) || (w_mplier_sh == 16'd0);
`else
    assign w_last = (w_cnt_nxt == 5'(ITER));
`endif

    assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_acc    <= 16'd0;
            r_cnt    <= 5'd0;
            r_ovf_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_prod   <= 16'd0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc    <= 16'd0;
                        r_cnt    <= 5'd0;
                        r_ovf_r  <= 1'b0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
                        if (i_b == 16'd0) begin
                            // Nothing to accumulate: report zero right away.
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_prod  <= 16'd0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= first_state(i_b[0]);
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= first_state(i_b[0]);
                        r_busy  <= 1'b1;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ADD: begin
                    // Without the grant every register simply holds.
                    if (i_alu_gnt) begin
                        r_acc   <= i_alu_Out;
                        r_ovf_r <= r_ovf_r | i_alu_OFL;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (i_alu_gnt) begin
                        r_mcand  <= i_alu_Out;
                        r_mplier <= w_mplier_sh;
                        r_cnt    <= w_cnt_nxt;
                        r_ovf_r  <= w_shift_ovf;
                        if (w_last) begin
                            // acc is untouched by SHIFT, so it is final here.
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_prod  <= r_acc;
                            r_ovf   <= w_shift_ovf;
                        end else begin
                            // mplier[1] becomes the LSB after this shift.
                            r_state <= r_mplier[1] ? ADD : SHIFT;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive is decoded from registered state only, so it stays constant
    // through any cycle in which the grant is withheld.
    always_comb begin
        o_alu_A  = 16'd0;
        o_alu_B  = 16'd0;
        o_alu_Op = OP_ADD;
        case (r_state)
            ADD: begin
                o_alu_A  = r_acc;
                o_alu_B  = r_mcand;
                o_alu_Op = OP_ADD;
            end
            SHIFT: begin
                o_alu_A  = r_mcand;
                o_alu_B  = 16'd1;
                o_alu_Op = OP_SLL;
            end
            default: begin
                o_alu_A  = 16'd0;
                o_alu_B  = 16'd0;
                o_alu_Op = OP_ADD;
            end
        endcase
    end

    assign o_alu_Cin  = 1'b0;
    assign o_alu_sign = 1'b0;
    assign o_busy     = r_busy;
    assign o_alu_req  = r_busy;
    assign o_done     = r_done;
    assign o_prod     = r_prod;
    assign o_ovf      = r_ovf;

endmodule
